// File: rtl/ddr_burst_arb.sv
// ddr_burst_arb: shares one ddr_ctrl user port between CH_NUM channels, one read or write
// burst at a time, using round-robin (MODE=0) or read-priority (MODE=1) selection.
module ddr_burst_arb #(
  parameter int CH_NUM  = 4,
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 10,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 4096,
  localparam int CH_W   = $clog2(CH_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ddr_init_done,
  input  logic [CH_NUM-1:0]        ch_wr_req,
  input  logic [CH_NUM-1:0]        ch_rd_req,
  input  logic [CH_NUM*ADDR_W-1:0] ch_wr_addr,
  input  logic [CH_NUM*ADDR_W-1:0] ch_rd_addr,
  input  logic [CH_NUM*LEN_W-1:0]  ch_wr_len,
  input  logic [CH_NUM*LEN_W-1:0]  ch_rd_len,
  input  logic [CH_NUM*DATA_W-1:0] ch_wr_data,
  output logic [CH_NUM-1:0]        ch_wr_data_req,
  output logic [CH_NUM-1:0]        ch_wr_finish,
  output logic [CH_NUM-1:0]        ch_rd_finish,
  output logic [DATA_W-1:0]        ch_rd_data,
  output logic [CH_NUM-1:0]        ch_rd_data_valid,
  output logic                     wr_burst_req,
  output logic                     rd_burst_req,
  output logic [ADDR_W-1:0]        wr_burst_addr,
  output logic [ADDR_W-1:0]        rd_burst_addr,
  output logic [LEN_W-1:0]         wr_burst_len,
  output logic [LEN_W-1:0]         rd_burst_len,
  output logic [DATA_W-1:0]        wr_burst_data,
  input  logic                     wr_burst_data_req,
  input  logic                     wr_burst_finish,
  input  logic                     rd_burst_finish,
  input  logic                     rd_burst_data_valid,
  input  logic [DATA_W-1:0]        rd_burst_data,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     cur_rd,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [1:0]               dbg_state
);

  localparam int SLOTS  = 2 * CH_NUM;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int SW1    = SLOT_W + 1;
  localparam int CW1    = CH_W + 1;
  localparam int CNT_W  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WR = 2'd1, S_RD = 2'd2, S_GAP = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  logic               cur_rd_q, cur_rd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SLOT_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               err_q, err_d;

  logic               grant_vld, grant_rd, grant;
  logic [CH_W-1:0]    grant_ch;
  logic               zero_len, in_burst, fin_in, wdog_hit, burst_end;
  logic [SLOTS-1:0]   req_vec;

  // Handshake: channel requests are levels held until their own finish pulse; *_burst_req
  // holds until ddr_ctrl finishes; data_req/data_valid pass through with zero latency.
  assign req_vec   = {ch_rd_req, ch_wr_req};
  assign zero_len  = (len_q == '0);
  assign in_burst  = (state_q == S_WR) || (state_q == S_RD);
  assign fin_in    = cur_rd_q ? rd_burst_finish : wr_burst_finish;
  assign wdog_hit  = !zero_len && !fin_in && (wdog_q == CNT_W'(TIMEOUT - 1));
  assign burst_end = in_burst && (zero_len || fin_in || wdog_hit);
  assign grant     = (state_q == S_IDLE) && ddr_init_done && grant_vld;

  always_comb begin : p_search
    logic [SW1-1:0] sum;
    logic [CW1-1:0] csum;
    grant_vld = 1'b0;
    grant_rd  = 1'b0;
    grant_ch  = '0;
    sum       = '0;
    csum      = '0;
    if (MODE == 0) begin
      for (int i = 0; i < SLOTS; i++) begin
        sum = SW1'(ptr_q) + SW1'(i);
        if (sum >= SW1'(SLOTS)) sum = sum - SW1'(SLOTS);
        if (!grant_vld && req_vec[sum[SLOT_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_rd  = (sum >= SW1'(CH_NUM));
          grant_ch  = grant_rd ? CH_W'(sum - SW1'(CH_NUM)) : CH_W'(sum);
        end
      end
    end else begin
      // Reads are searched first; writes only win when no read is pending at all.
      for (int i = 0; i < CH_NUM; i++) begin
        csum = CW1'(rd_ptr_q) + CW1'(i);
        if (csum >= CW1'(CH_NUM)) csum = csum - CW1'(CH_NUM);
        if (!grant_vld && ch_rd_req[csum[CH_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_rd  = 1'b1;
          grant_ch  = csum[CH_W-1:0];
        end
      end
      for (int i = 0; i < CH_NUM; i++) begin
        csum = CW1'(wr_ptr_q) + CW1'(i);
        if (csum >= CW1'(CH_NUM)) csum = csum - CW1'(CH_NUM);
        if (!grant_vld && ch_wr_req[csum[CH_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_rd  = 1'b0;
          grant_ch  = csum[CH_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cur_ch_q <= '0;
      cur_rd_q <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      ptr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wdog_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      cur_rd_q <= cur_rd_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      ptr_q    <= ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wdog_q   <= wdog_d;
      err_q    <= err_d;
    end
  end

  always_comb begin : p_next
    logic [SW1-1:0] slot_nx;
    logic [CW1-1:0] ch_nx;
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    cur_rd_d = cur_rd_q;
    addr_d   = addr_q;
    len_d    = len_q;
    ptr_d    = ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wdog_d   = in_burst ? wdog_q + CNT_W'(1) : wdog_q;
    err_d    = err_q | (in_burst && wdog_hit);
    slot_nx  = grant_rd ? SW1'(grant_ch) + SW1'(CH_NUM) + SW1'(1) : SW1'(grant_ch) + SW1'(1);
    if (slot_nx >= SW1'(SLOTS)) slot_nx = '0;
    ch_nx    = CW1'(grant_ch) + CW1'(1);
    if (ch_nx >= CW1'(CH_NUM)) ch_nx = '0;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d  = grant_rd ? S_RD : S_WR;
          cur_ch_d = grant_ch;
          cur_rd_d = grant_rd;
          addr_d   = grant_rd ? ch_rd_addr[int'(grant_ch)*ADDR_W +: ADDR_W]
                              : ch_wr_addr[int'(grant_ch)*ADDR_W +: ADDR_W];
          len_d    = grant_rd ? ch_rd_len[int'(grant_ch)*LEN_W +: LEN_W]
                              : ch_wr_len[int'(grant_ch)*LEN_W +: LEN_W];
          wdog_d   = '0;
          ptr_d    = SLOT_W'(slot_nx);
          if (grant_rd) rd_ptr_d = CH_W'(ch_nx);
          else          wr_ptr_d = CH_W'(ch_nx);
        end
      end
      S_WR, S_RD: if (burst_end) state_d = S_GAP;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin : p_out
    wr_burst_req     = (state_q == S_WR) && !zero_len;
    rd_burst_req     = (state_q == S_RD) && !zero_len;
    ch_wr_data_req   = '0;
    ch_wr_finish     = '0;
    ch_rd_finish     = '0;
    ch_rd_data_valid = '0;
    wr_burst_data    = '0;
    ch_rd_data       = '0;
    if (state_q == S_WR) begin
      wr_burst_data            = ch_wr_data[int'(cur_ch_q)*DATA_W +: DATA_W];
      ch_wr_data_req[cur_ch_q] = wr_burst_data_req;
      ch_wr_finish[cur_ch_q]   = burst_end;
    end
    if (state_q == S_RD) begin
      ch_rd_data                 = rd_burst_data;
      ch_rd_data_valid[cur_ch_q] = rd_burst_data_valid;
      ch_rd_finish[cur_ch_q]     = burst_end;
    end
  end

  assign wr_burst_addr = addr_q;
  assign rd_burst_addr = addr_q;
  assign wr_burst_len  = len_q;
  assign rd_burst_len  = len_q;
  assign cur_ch        = cur_ch_q;
  assign cur_rd        = cur_rd_q;
  assign busy          = (state_q != S_IDLE);
  assign err_timeout   = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ddr_burst_arb.sv
// Directed bench for ddr_burst_arb: dut_a is round-robin with the default watchdog,
// dut_b is read-priority with a 16-cycle watchdog; both share the same stimulus.
module tb_ddr_burst_arb;
  localparam int CH = 4, AW = 25, DW = 32, LW = 10;

  logic clk = 1'b0;
  logic rst, init;
  logic [CH-1:0]    wr_req, rd_req;
  logic [CH*AW-1:0] wr_addr, rd_addr;
  logic [CH*LW-1:0] wr_len, rd_len;
  logic [CH*DW-1:0] wr_data;
  logic wr_burst_data_req, wr_burst_finish, rd_burst_finish, rd_burst_data_valid;
  logic [DW-1:0] rd_burst_data;

  logic [CH-1:0] a_wdreq, a_wfin, a_rfin, a_rvalid, b_wdreq, b_wfin, b_rfin, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata, a_wbdata, b_wbdata;
  logic a_wr_burst_req, a_rd_burst_req, b_wr_burst_req, b_rd_burst_req;
  logic [AW-1:0] a_waddr, a_raddr, b_waddr, b_raddr;
  logic [LW-1:0] a_wlen, a_rlen, b_wlen, b_rlen;
  logic [1:0] a_cur_ch, b_cur_ch, a_dbg, b_dbg;
  logic a_cur_rd, b_cur_rd, a_busy, b_busy, a_err, b_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ddr_burst_arb #(.CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MODE(0), .TIMEOUT(4096)) dut_a (
    .clk(clk), .rst(rst), .ddr_init_done(init),
    .ch_wr_req(wr_req), .ch_rd_req(rd_req), .ch_wr_addr(wr_addr), .ch_rd_addr(rd_addr),
    .ch_wr_len(wr_len), .ch_rd_len(rd_len), .ch_wr_data(wr_data),
    .ch_wr_data_req(a_wdreq), .ch_wr_finish(a_wfin), .ch_rd_finish(a_rfin),
    .ch_rd_data(a_rdata), .ch_rd_data_valid(a_rvalid),
    .wr_burst_req(a_wr_burst_req), .rd_burst_req(a_rd_burst_req),
    .wr_burst_addr(a_waddr), .rd_burst_addr(a_raddr), .wr_burst_len(a_wlen), .rd_burst_len(a_rlen),
    .wr_burst_data(a_wbdata), .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_finish(wr_burst_finish), .rd_burst_finish(rd_burst_finish),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .cur_ch(a_cur_ch), .cur_rd(a_cur_rd), .busy(a_busy), .err_timeout(a_err), .dbg_state(a_dbg)
  );

  ddr_burst_arb #(.CH_NUM(CH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MODE(1), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .ddr_init_done(init),
    .ch_wr_req(wr_req), .ch_rd_req(rd_req), .ch_wr_addr(wr_addr), .ch_rd_addr(rd_addr),
    .ch_wr_len(wr_len), .ch_rd_len(rd_len), .ch_wr_data(wr_data),
    .ch_wr_data_req(b_wdreq), .ch_wr_finish(b_wfin), .ch_rd_finish(b_rfin),
    .ch_rd_data(b_rdata), .ch_rd_data_valid(b_rvalid),
    .wr_burst_req(b_wr_burst_req), .rd_burst_req(b_rd_burst_req),
    .wr_burst_addr(b_waddr), .rd_burst_addr(b_raddr), .wr_burst_len(b_wlen), .rd_burst_len(b_rlen),
    .wr_burst_data(b_wbdata), .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_finish(wr_burst_finish), .rd_burst_finish(rd_burst_finish),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_data(rd_burst_data),
    .cur_ch(b_cur_ch), .cur_rd(b_cur_rd), .busy(b_busy), .err_timeout(b_err), .dbg_state(b_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; init = 1'b1;
    wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
    rd_burst_data_valid = 1'b0; rd_burst_data = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) until the chosen DUT raises a downstream burst request.
  task automatic wait_req(input bit on_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (on_b ? (b_wr_burst_req || b_rd_burst_req) : (a_wr_burst_req || a_rd_burst_req)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b1; wr_req = '1; rd_req = '1; wr_len = {CH{10'd5}}; rd_len = {CH{10'd5}};
    repeat (3) tick();
    @(negedge clk);
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, want 0", a_busy); end
    n_tests++; if (a_wr_burst_req !== 1'b0 || a_rd_burst_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b%b, want 00", a_wr_burst_req, a_rd_burst_req); end
    n_tests++; if (a_cur_ch !== 2'd0 || a_cur_rd !== 1'b0) begin n_fail++; $display("FAIL reset_cur: got ch %0d rd %b, want 0/0", a_cur_ch, a_cur_rd); end
    n_tests++; if (a_err !== 1'b0 || b_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b%b, want 00", a_err, b_err); end
    n_tests++; if (a_wfin !== 4'b0 || a_rfin !== 4'b0 || a_waddr !== '0) begin n_fail++; $display("FAIL reset_fin: got wfin %b rfin %b addr %h, want 0", a_wfin, a_rfin, a_waddr); end
  endtask

  task automatic test_single_wr();
    int pulses, others, drops;
    do_reset();
    wr_req[2] = 1'b1; wr_addr[2*AW +: AW] = 25'h000100; wr_len[2*LW +: LW] = 10'd128;
    @(negedge clk);
    n_tests++; if (a_wr_burst_req !== 1'b0) begin n_fail++; $display("FAIL wr_grant_cycle_req: got %b, want 0", a_wr_burst_req); end
    tick(); @(negedge clk);
    n_tests++; if (a_wr_burst_req !== 1'b1) begin n_fail++; $display("FAIL wr_req_after_grant: got %b, want 1", a_wr_burst_req); end
    n_tests++; if (a_waddr !== 25'h000100 || a_wlen !== 10'd128) begin n_fail++; $display("FAIL wr_addr_len: got %h/%0d, want 000100/128", a_waddr, a_wlen); end
    n_tests++; if (a_cur_ch !== 2'd2 || a_cur_rd !== 1'b0) begin n_fail++; $display("FAIL wr_cur: got ch %0d rd %b, want 2/0", a_cur_ch, a_cur_rd); end
    n_tests++; if (a_wbdata !== 32'hA5A50002) begin n_fail++; $display("FAIL wr_data_mux: got %h, want a5a50002", a_wbdata); end
    pulses = 0; others = 0; drops = 0;
    for (int i = 0; i < 128; i++) begin
      tick(); wr_burst_data_req = 1'b1;
      @(negedge clk);
      if (a_wdreq[2] === 1'b1) pulses++;
      if ((a_wdreq & 4'b1011) !== 4'b0) others++;
      if (a_wr_burst_req !== 1'b1) drops++;
    end
    n_tests++; if (pulses !== 128) begin n_fail++; $display("FAIL wr_data_req_count: got %0d, want 128", pulses); end
    n_tests++; if (others !== 0 || drops !== 0) begin n_fail++; $display("FAIL wr_data_req_other: got others %0d drops %0d, want 0/0", others, drops); end
    tick(); wr_burst_data_req = 1'b0; wr_burst_finish = 1'b1;
    @(negedge clk);
    n_tests++; if (a_wfin !== 4'b0100 || a_rfin !== 4'b0) begin n_fail++; $display("FAIL wr_finish: got wfin %b rfin %b, want 0100/0000", a_wfin, a_rfin); end
    tick(); wr_burst_finish = 1'b0; wr_req[2] = 1'b0;
    @(negedge clk);
    n_tests++; if (a_wr_burst_req !== 1'b0 || a_wfin !== 4'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL wr_gap: got req %b fin %b busy %b, want 0/0000/1", a_wr_burst_req, a_wfin, a_busy); end
    tick(); @(negedge clk);
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL wr_idle: got busy %b, want 0", a_busy); end
  endtask

  task automatic test_rr_all();
    bit ok;
    int fin_cyc, got;
    do_reset();
    for (int k = 0; k < CH; k++) begin
      wr_len[k*LW +: LW] = 10'd2; rd_len[k*LW +: LW] = 10'd2;
    end
    wr_req = '1; rd_req = '1; fin_cyc = 0;
    for (int k = 0; k < 9; k++) begin
      wait_req(1'b0, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rr_wait grant %0d: no burst_req within 40 cycles, want one", k); break; end
      got = a_cur_rd ? CH + int'(a_cur_ch) : int'(a_cur_ch);
      n_tests++; if (got !== k % 8) begin n_fail++; $display("FAIL rr_order grant %0d: got slot %0d, want %0d", k, got, k % 8); end
      if (k > 0) begin
        n_tests++; if (cyc - fin_cyc !== 3) begin n_fail++; $display("FAIL rr_gap grant %0d: got %0d cycles finish-to-req, want 3", k, cyc - fin_cyc); end
      end
      tick();
      if (a_cur_rd) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
      @(negedge clk); fin_cyc = cyc;
      tick(); rd_burst_finish = 1'b0; wr_burst_finish = 1'b0;
    end
    wr_req = '0; rd_req = '0;
  endtask

  task automatic test_mode1();
    bit ok;
    int got;
    do_reset();
    wr_len[1*LW +: LW] = 10'd3; rd_len[3*LW +: LW] = 10'd3; rd_len[0 +: LW] = 10'd3;
    wr_req[1] = 1'b1; rd_req[3] = 1'b1;
    wait_req(1'b1, ok);
    got = b_cur_rd ? CH + int'(b_cur_ch) : int'(b_cur_ch);
    n_tests++; if (!ok || got !== 7) begin n_fail++; $display("FAIL m1_first: got slot %0d ok %b, want 7 (R3)", got, ok); end
    tick(); rd_req[0] = 1'b1;
    tick(); rd_burst_finish = 1'b1;
    @(negedge clk);
    n_tests++; if (b_rfin !== 4'b1000) begin n_fail++; $display("FAIL m1_r3_finish: got %b, want 1000", b_rfin); end
    tick(); rd_burst_finish = 1'b0; rd_req[3] = 1'b0;
    wait_req(1'b1, ok);
    got = b_cur_rd ? CH + int'(b_cur_ch) : int'(b_cur_ch);
    n_tests++; if (!ok || got !== 4) begin n_fail++; $display("FAIL m1_second: got slot %0d ok %b, want 4 (R0)", got, ok); end
    tick(); rd_burst_data_valid = 1'b1; rd_burst_data = 32'hDEADBEEF; wr_burst_finish = 1'b1;
    @(negedge clk);
    n_tests++; if (b_rvalid !== 4'b0001 || b_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL m1_rd_data: got valid %b data %h, want 0001/deadbeef", b_rvalid, b_rdata); end
    n_tests++; if (b_wfin !== 4'b0 || b_rfin !== 4'b0 || b_rd_burst_req !== 1'b1) begin n_fail++; $display("FAIL m1_wrong_dir_finish: got wfin %b rfin %b req %b, want 0/0/1", b_wfin, b_rfin, b_rd_burst_req); end
    tick(); rd_burst_data_valid = 1'b0; wr_burst_finish = 1'b0; rd_burst_finish = 1'b1;
    @(negedge clk);
    n_tests++; if (b_rfin !== 4'b0001) begin n_fail++; $display("FAIL m1_r0_finish: got %b, want 0001", b_rfin); end
    tick(); rd_burst_finish = 1'b0; rd_req[0] = 1'b0;
    wait_req(1'b1, ok);
    got = b_cur_rd ? CH + int'(b_cur_ch) : int'(b_cur_ch);
    n_tests++; if (!ok || got !== 1) begin n_fail++; $display("FAIL m1_third: got slot %0d ok %b, want 1 (W1)", got, ok); end
    tick(); wr_burst_finish = 1'b1;
    @(negedge clk);
    n_tests++; if (b_wfin !== 4'b0010) begin n_fail++; $display("FAIL m1_w1_finish: got %b, want 0010", b_wfin); end
    tick(); wr_burst_finish = 1'b0; wr_req = '0;
  endtask

  task automatic test_zero_len();
    do_reset();
    rd_req[1] = 1'b1; rd_len[1*LW +: LW] = 10'd0;
    @(negedge clk);
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL zl_grant_cycle: got busy %b, want 0", a_busy); end
    tick(); @(negedge clk);
    n_tests++; if (a_rd_burst_req !== 1'b0 || a_rfin !== 4'b0010 || a_busy !== 1'b1) begin n_fail++; $display("FAIL zl_finish: got req %b fin %b busy %b, want 0/0010/1", a_rd_burst_req, a_rfin, a_busy); end
    tick(); rd_req[1] = 1'b0;
    @(negedge clk);
    n_tests++; if (a_rd_burst_req !== 1'b0 || a_rfin !== 4'b0 || a_busy !== 1'b1) begin n_fail++; $display("FAIL zl_gap: got req %b fin %b busy %b, want 0/0000/1", a_rd_burst_req, a_rfin, a_busy); end
    tick(); @(negedge clk);
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL zl_idle: got busy %b, want 0", a_busy); end
  endtask

  task automatic test_timeout();
    bit ok;
    int hi, fins;
    do_reset();
    wr_req[0] = 1'b1; wr_len[0 +: LW] = 10'd5;
    wait_req(1'b1, ok);
    hi = 0; fins = 0;
    while (ok && b_wr_burst_req && hi < 40) begin
      hi++;
      if (b_wfin === 4'b0001) fins++;
      @(negedge clk);
    end
    wr_req = '0;
    n_tests++; if (hi !== 16) begin n_fail++; $display("FAIL to_req_len: got %0d cycles, want 16", hi); end
    n_tests++; if (fins !== 1) begin n_fail++; $display("FAIL to_finish_pulses: got %0d, want 1", fins); end
    n_tests++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL to_err_set: got %b, want 1", b_err); end
    repeat (5) tick();
    @(negedge clk);
    n_tests++; if (b_err !== 1'b1 || b_busy !== 1'b0) begin n_fail++; $display("FAIL to_err_sticky: got err %b busy %b, want 1/0", b_err, b_busy); end
    do_reset();
    @(negedge clk);
    n_tests++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL to_err_cleared: got %b, want 0", b_err); end
  endtask

  task automatic test_rst_init();
    bit ok;
    int bad, got;
    do_reset();
    wr_req[1] = 1'b1; wr_len[1*LW +: LW] = 10'd8;
    wait_req(1'b0, ok);
    n_tests++; if (!ok || a_cur_ch !== 2'd1) begin n_fail++; $display("FAIL ri_first_grant: got ch %0d ok %b, want 1", a_cur_ch, ok); end
    tick(); wr_burst_data_req = 1'b1;
    @(negedge clk);
    n_tests++; if (a_wdreq !== 4'b0010) begin n_fail++; $display("FAIL ri_data_req: got %b, want 0010", a_wdreq); end
    tick(); rst = 1'b1;
    tick(); @(negedge clk);
    n_tests++; if (a_busy !== 1'b0 || a_wr_burst_req !== 1'b0 || a_wdreq !== 4'b0 || a_cur_ch !== 2'd0) begin n_fail++; $display("FAIL ri_mid_rst: got busy %b req %b dreq %b ch %0d, want 0/0/0000/0", a_busy, a_wr_burst_req, a_wdreq, a_cur_ch); end
    rst = 1'b0; init = 1'b0; wr_burst_data_req = 1'b0; rd_req[0] = 1'b1;
    bad = 0;
    repeat (6) begin @(negedge clk); if (a_busy || a_wr_burst_req || a_rd_burst_req) bad++; end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL ri_init_low: got %0d busy cycles, want 0", bad); end
    init = 1'b1;
    wait_req(1'b0, ok);
    got = a_cur_rd ? CH + int'(a_cur_ch) : int'(a_cur_ch);
    n_tests++; if (!ok || got !== 1) begin n_fail++; $display("FAIL ri_ptr_reset: got slot %0d ok %b, want 1", got, ok); end
    tick(); init = 1'b0;
    tick(); wr_burst_finish = 1'b1;
    @(negedge clk);
    n_tests++; if (a_wfin !== 4'b0010) begin n_fail++; $display("FAIL ri_init_fall_finish: got %b, want 0010", a_wfin); end
    tick(); wr_burst_finish = 1'b0; wr_req[1] = 1'b0;
    bad = 0;
    repeat (6) begin @(negedge clk); if (a_wr_burst_req || a_rd_burst_req) bad++; end
    n_tests++; if (bad !== 0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL ri_no_grant: got %0d req cycles busy %b, want 0/0", bad, a_busy); end
    rd_req = '0; init = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL tb_watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; init = 1'b0; wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0;
    wr_len = '0; rd_len = '0;
    wr_data = {32'hA5A50003, 32'hA5A50002, 32'hA5A50001, 32'hA5A50000};
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
    rd_burst_data_valid = 1'b0; rd_burst_data = '0;
    test_reset();
    test_single_wr();
    test_rr_all();
    test_mode1();
    test_zero_len();
    test_timeout();
    test_rst_init();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
